// File: rtl/sawtooth_pkg.sv
// Shared types and constants for the multi-channel ramp generator.
package sawtooth_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHARGE    = 2'd1,
        DISCHARGE = 2'd2,
        FALL      = 2'd3
    } ramp_state_e;

    typedef enum logic {
        SAW = 1'b0,
        TRI = 1'b1
    } ramp_mode_e;

    localparam logic [1:0] CFG_SEL_STEP = 2'd0;
    localparam logic [1:0] CFG_SEL_TOP  = 2'd1;
    localparam logic [1:0] CFG_SEL_MODE = 2'd2;

endpackage

// File: rtl/sawtooth_ramp_channel.sv
// One ramp channel: config registers, charge/discharge/fall FSM and dwell counter.
// Optional wrap_pulse output when SAWTOOTH_WRAP_PULSE_EN is defined.
module ramp_channel #(
    parameter int WIDTH      = 12,
    parameter int DIS_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_sel,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic             enable,
    output logic [WIDTH-1:0] ramp,
    output logic             discharging
`ifdef SAWTOOTH_WRAP_PULSE_EN
    ,
    output logic             wrap_pulse
`endif
);
    import sawtooth_pkg::*;

    localparam int CW = (DIS_CYCLES > 1) ? $clog2(DIS_CYCLES) : 1;
    localparam logic [WIDTH-1:0] STEP_ONE = WIDTH'(1'b1);

    logic [WIDTH-1:0] step_r;
    logic [WIDTH-1:0] top_r;
    ramp_mode_e       mode_r;
    ramp_state_e      state_r;
    logic [WIDTH-1:0] ramp_r;
    logic             dis_r;
    logic [CW-1:0]    cnt_r;

    logic [WIDTH-1:0] step_eff_s;
    logic [WIDTH:0]   sum_s;
    logic             top_hit_s;

    // A zero step is treated as one so the ramp always advances.
    assign step_eff_s = (step_r == '0) ? STEP_ONE : step_r;
    assign sum_s      = {1'b0, ramp_r} + {1'b0, step_eff_s};
    assign top_hit_s  = (sum_s >= {1'b0, top_r});

    // Per-channel configuration registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_r <= STEP_ONE;
            top_r  <= '1;
            mode_r <= SAW;
        end else if (cfg_we) begin
            case (cfg_sel)
                CFG_SEL_STEP: step_r <= cfg_data;
                CFG_SEL_TOP:  top_r  <= cfg_data;
                CFG_SEL_MODE: mode_r <= ramp_mode_e'(cfg_data[0]);
                default:      mode_r <= mode_r;
            endcase
        end
    end

    // Ramp FSM; state names the action taken at the next edge, outputs are registered.
    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            state_r <= IDLE;
            ramp_r  <= '0;
            dis_r   <= 1'b0;
            cnt_r   <= '0;
        end else begin
            dis_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    state_r <= CHARGE;
                    ramp_r  <= '0;
                end
                CHARGE: begin
                    if (top_hit_s) begin
                        ramp_r  <= top_r;
                        cnt_r   <= '0;
                        state_r <= (mode_r == TRI) ? FALL : DISCHARGE;
                    end else begin
                        ramp_r <= sum_s[WIDTH-1:0];
                    end
                end
                DISCHARGE: begin
                    ramp_r <= '0;
                    dis_r  <= 1'b1;
                    if (cnt_r == CW'(DIS_CYCLES - 1)) begin
                        cnt_r   <= '0;
                        state_r <= CHARGE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1'b1);
                    end
                end
                FALL: begin
                    if (ramp_r <= step_eff_s) begin
                        ramp_r  <= '0;
                        state_r <= CHARGE;
                    end else begin
                        ramp_r <= ramp_r - step_eff_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ramp_r  <= '0;
                end
            endcase
        end
    end

    assign ramp        = ramp_r;
    assign discharging = dis_r;

`ifdef SAWTOOTH_WRAP_PULSE_EN
    logic wrap_r;

    // One-cycle marker aligned with the cycle ramp shows top after a charge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrap_r <= 1'b0;
        end else begin
            wrap_r <= enable && (state_r == CHARGE) && top_hit_s;
        end
    end

    assign wrap_pulse = wrap_r;
`endif

endmodule

// File: rtl/sawtooth_gen_multi.sv
// Multi-channel ramp generator top: decodes config writes and packs channel outputs.
// Defining SAWTOOTH_WRAP_PULSE_EN adds the per-channel wrap_pulse output.
module sawtooth_gen_multi #(
    parameter int  WIDTH      = 12,
    parameter int  CHANNELS   = 4,
    parameter int  DIS_CYCLES = 2,
    localparam int CH_AW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_we,
    input  logic [CH_AW-1:0]          cfg_ch,
    input  logic [1:0]                cfg_sel,
    input  logic [WIDTH-1:0]          cfg_data,
    input  logic [CHANNELS-1:0]       enable,
    output logic [CHANNELS*WIDTH-1:0] ramp_out,
    output logic [CHANNELS-1:0]       discharging
`ifdef SAWTOOTH_WRAP_PULSE_EN
    ,
    output logic [CHANNELS-1:0]       wrap_pulse
`endif
);
    import sawtooth_pkg::*;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic ch_we_s;

        // Addresses at or beyond CHANNELS match no channel and are dropped.
        assign ch_we_s = cfg_we && (cfg_ch == CH_AW'(i));

        ramp_channel #(
            .WIDTH      (WIDTH),
            .DIS_CYCLES (DIS_CYCLES)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .cfg_we      (ch_we_s),
            .cfg_sel     (cfg_sel),
            .cfg_data    (cfg_data),
            .enable      (enable[i]),
            .ramp        (ramp_out[i*WIDTH +: WIDTH]),
            .discharging (discharging[i])
`ifdef SAWTOOTH_WRAP_PULSE_EN
            ,
            .wrap_pulse  (wrap_pulse[i])
`endif
        );
    end

endmodule
